// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the byte-serial memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
    typedef enum logic [1:0] {REQ_IF, REQ_LD, REQ_ST} req_id_e;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SW = 2'b10;

    localparam logic [1:0] IO_SEL_DEFAULT = 2'b11;

    // Load funct3[1:0] and store size share the same 1/2/4 byte encoding.
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            ST_SB:   return 3'd1;
            ST_SH:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ld_extend.sv
// Sign/zero extension of an assembled little-endian load word by funct3.
module mem_ld_extend
    import mem_arb_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  op,
    output logic [31:0] data
);

    always_comb begin
        data = raw;
        case (op)
            LD_LB:   data = {{24{raw[7]}}, raw[7:0]};
            LD_LH:   data = {{16{raw[15]}}, raw[15:0]};
            LD_LBU:  data = {24'b0, raw[7:0]};
            LD_LHU:  data = {16'b0, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-serial RAM/IO arbiter for fetch, load and store requesters.
// Optional IO write back-pressure is enabled by defining MEM_IO_STALL_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter logic [1:0]  IO_SEL = IO_SEL_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [2:0]        ld_op,
    output logic              ld_done,
    output logic [DATA_W-1:0] ld_data,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [1:0]        st_size,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_done,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    state_e            state_q, state_d;
    req_id_e           id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d, mem_a_q, mem_a_d;
    logic [2:0]        op_q, op_d, cnt_q, cnt_d, nbytes;
    logic [31:0]       data_q, data_d, raw_q, raw_d, raw_merged, ext_data;
    logic [7:0]        dout_q, dout_d, wr_byte;
    logic              wr_q, wr_d;
    logic              if_done_q, if_done_d, ld_done_q, ld_done_d, st_done_q, st_done_d;
    logic [DATA_W-1:0] if_data_q, if_data_d, ld_data_q, ld_data_d;
    logic [1:0]        cap_idx;
    logic              st_stall, wr_stall;

`ifdef MEM_IO_STALL_EN
    assign st_stall = (st_addr[17:16] == IO_SEL) && io_buffer_full;
    assign wr_stall = (addr_q[17:16] == IO_SEL) && io_buffer_full;
`else
    logic unused_io_buffer_full;
    assign unused_io_buffer_full = io_buffer_full;
    assign st_stall = 1'b0;
    assign wr_stall = 1'b0;
`endif

    assign nbytes  = byte_count(op_q[1:0]);
    // Byte captured at E(k) is byte k-2 of the access.
    assign cap_idx = cnt_q[1:0] - 2'd2;

    always_comb begin
        raw_merged = raw_q;
        unique case (cap_idx)
            2'd0: raw_merged[7:0]   = mem_din;
            2'd1: raw_merged[15:8]  = mem_din;
            2'd2: raw_merged[23:16] = mem_din;
            2'd3: raw_merged[31:24] = mem_din;
        endcase
    end

    always_comb begin
        wr_byte = data_q[7:0];
        unique case (cnt_q[1:0])
            2'd0: wr_byte = data_q[7:0];
            2'd1: wr_byte = data_q[15:8];
            2'd2: wr_byte = data_q[23:16];
            2'd3: wr_byte = data_q[31:24];
        endcase
    end

    mem_ld_extend u_ld_extend (
        .raw  (raw_merged),
        .op   (op_q),
        .data (ext_data)
    );

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        raw_d     = raw_q;
        mem_a_d   = mem_a_q;
        dout_d    = dout_q;
        wr_d      = 1'b0;
        if_done_d = 1'b0;
        ld_done_d = 1'b0;
        st_done_d = 1'b0;
        if_data_d = if_data_q;
        ld_data_d = ld_data_q;

        unique case (state_q)
            IDLE: begin
                if (st_req) begin
                    id_d    = REQ_ST;
                    addr_d  = st_addr;
                    op_d    = {1'b0, st_size};
                    data_d  = st_data;
                    state_d = WRITE;
                    cnt_d   = 3'd0;
                    if (!st_stall) begin
                        mem_a_d = st_addr;
                        dout_d  = st_data[7:0];
                        wr_d    = 1'b1;
                        cnt_d   = 3'd1;
                    end
                end else if (ld_req && !rollback) begin
                    id_d    = REQ_LD;
                    addr_d  = ld_addr;
                    op_d    = ld_op;
                    mem_a_d = ld_addr;
                    raw_d   = '0;
                    cnt_d   = 3'd1;
                    state_d = READ;
                end else if (if_req && !rollback) begin
                    id_d    = REQ_IF;
                    addr_d  = if_addr;
                    op_d    = LD_LW;
                    mem_a_d = if_addr;
                    raw_d   = '0;
                    cnt_d   = 3'd1;
                    state_d = READ;
                end
            end
            READ: begin
                if (rollback) begin
                    state_d = IDLE;
                end else begin
                    if (cnt_q < nbytes) mem_a_d = addr_q + ADDR_W'(cnt_q);
                    if (cnt_q >= 3'd2) raw_d = raw_merged;
                    if (cnt_q == nbytes + 3'd1) begin
                        state_d = DONE;
                        if (id_q == REQ_IF) begin
                            if_done_d = 1'b1;
                            if_data_d = raw_merged;
                        end else begin
                            ld_done_d = 1'b1;
                            ld_data_d = ext_data;
                        end
                    end
                    cnt_d = cnt_q + 3'd1;
                end
            end
            WRITE: begin
                if (cnt_q == nbytes) begin
                    st_done_d = 1'b1;
                    state_d   = DONE;
                end else if (!wr_stall) begin
                    mem_a_d = addr_q + ADDR_W'(cnt_q);
                    dout_d  = wr_byte;
                    wr_d    = 1'b1;
                    cnt_d   = cnt_q + 3'd1;
                end
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            id_q      <= REQ_IF;
            addr_q    <= '0;
            op_q      <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            raw_q     <= '0;
            mem_a_q   <= '0;
            dout_q    <= '0;
            wr_q      <= 1'b0;
            if_done_q <= 1'b0;
            ld_done_q <= 1'b0;
            st_done_q <= 1'b0;
            if_data_q <= '0;
            ld_data_q <= '0;
        end else if (rdy) begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            raw_q     <= raw_d;
            mem_a_q   <= mem_a_d;
            dout_q    <= dout_d;
            wr_q      <= wr_d;
            if_done_q <= if_done_d;
            ld_done_q <= ld_done_d;
            st_done_q <= st_done_d;
            if_data_q <= if_data_d;
            ld_data_q <= ld_data_d;
        end
    end

    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign ld_done  = ld_done_q;
    assign ld_data  = ld_data_q;
    assign st_done  = st_done_q;
    assign mem_a    = mem_a_q;
    assign mem_dout = dout_q;
    // Gating by rdy keeps a frozen write from striking the RAM more than once.
    assign mem_wr   = wr_q & rdy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a registered-read byte RAM model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback;
    logic        if_req, ld_req, st_req;
    logic [31:0] if_addr, ld_addr, st_addr, st_data;
    logic [2:0]  ld_op;
    logic [1:0]  st_size;
    logic        if_done, ld_done, st_done, mem_wr, io_buffer_full;
    logic [31:0] if_data, ld_data, mem_a;
    logic [7:0]  mem_din, mem_dout;

    logic [7:0]  mem [0:262143];
    logic        pre_we = 1'b0;
    logic [17:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;
    int          wr_count = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .rollback       (rollback),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .ld_req         (ld_req),
        .ld_addr        (ld_addr),
        .ld_op          (ld_op),
        .ld_done        (ld_done),
        .ld_data        (ld_data),
        .st_req         (st_req),
        .st_addr        (st_addr),
        .st_size        (st_size),
        .st_data        (st_data),
        .st_done        (st_done),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_wr) mem[mem_a[17:0]] <= mem_dout;
        if (mem_wr) wr_count <= wr_count + 1;
        mem_din <= mem[mem_a[17:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [17:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++;
        if ({if_done, ld_done, st_done, mem_wr} !== 4'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=0000", {if_done, ld_done, st_done, mem_wr});
        end
        total++;
        if (if_data !== 32'h0 || ld_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_data got if=%h ld=%h want 0", if_data, ld_data);
        end
        total++;
        if (mem_a !== 32'h0 || mem_dout !== 8'h0) begin
            bad++;
            $display("FAIL reset_bus got a=%h d=%h want 0", mem_a, mem_dout);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_sw();
        logic [7:0] exp_b [4];
        int base;
        exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        base = wr_count;
        st_addr = 32'h100; st_size = ST_SW; st_data = 32'hDEADBEEF; st_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (mem_wr !== 1'b1 || mem_a !== 32'h100 + i || mem_dout !== exp_b[i] || st_done) begin
                bad++;
                $display("FAIL sw_byte%0d got wr=%b a=%h d=%h done=%b want wr=1 a=%h d=%h done=0",
                         i, mem_wr, mem_a, mem_dout, st_done, 32'h100 + i, exp_b[i]);
            end
        end
        tick();
        total++;
        if (st_done !== 1'b1 || mem_wr !== 1'b0) begin
            bad++;
            $display("FAIL sw_done got done=%b wr=%b want done=1 wr=0", st_done, mem_wr);
        end
        st_req = 1'b0;
        tick();
        total++;
        if (st_done !== 1'b0) begin
            bad++;
            $display("FAIL sw_done_pulse got=%b want=0", st_done);
        end
        total++;
        if (wr_count - base != 4 || {mem[259], mem[258], mem[257], mem[256]} !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL sw_mem got strobes=%0d word=%h want 4 deadbeef", wr_count - base,
                     {mem[259], mem[258], mem[257], mem[256]});
        end
    endtask

    task automatic test_load();
        logic [31:0] addr [4];
        logic [2:0]  op [4];
        logic [31:0] exp_d [4];
        int          lat [4];
        int          n;
        addr  = '{32'h200, 32'h200, 32'h1FF, 32'h100};
        op    = '{LD_LB, LD_LBU, LD_LH, LD_LW};
        exp_d = '{32'hFFFFFF80, 32'h00000080, 32'h00007F80, 32'hDEADBEEF};
        lat   = '{3, 3, 4, 6};
        poke(18'h200, 8'h80);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                poke(18'h1FF, 8'h80);
                poke(18'h200, 8'h7F);
            end
            ld_addr = addr[i]; ld_op = op[i]; ld_req = 1'b1;
            n = 0;
            while (!ld_done && n < 20) begin
                tick();
                n++;
            end
            ld_req = 1'b0;
            total++;
            if (n != lat[i]) begin
                bad++;
                $display("FAIL load%0d_latency got=%0d want=%0d", i, n, lat[i]);
            end
            total++;
            if (ld_data !== exp_d[i]) begin
                bad++;
                $display("FAIL load%0d_data got=%h want=%h", i, ld_data, exp_d[i]);
            end
            tick();
            total++;
            if (ld_done !== 1'b0) begin
                bad++;
                $display("FAIL load%0d_pulse got=%b want=0", i, ld_done);
            end
        end
    endtask

    task automatic test_priority();
        int t_st, t_ld, t_if;
        logic [31:0] ld_v, if_v;
        t_st = -1; t_ld = -1; t_if = -1; ld_v = '0; if_v = '0;
        st_addr = 32'h400; st_size = ST_SB; st_data = 32'h0000005A;
        ld_addr = 32'h100; ld_op = LD_LBU; if_addr = 32'h100;
        st_req = 1'b1; ld_req = 1'b1; if_req = 1'b1;
        for (int t = 1; t <= 40 && t_if < 0; t++) begin
            tick();
            if (st_done) begin t_st = t; st_req = 1'b0; end
            if (ld_done) begin t_ld = t; ld_req = 1'b0; ld_v = ld_data; end
            if (if_done) begin t_if = t; if_req = 1'b0; if_v = if_data; end
        end
        st_req = 1'b0; ld_req = 1'b0; if_req = 1'b0;
        tick();
        total++;
        if (t_st != 2 || t_ld != 6 || t_if != 13) begin
            bad++;
            $display("FAIL prio_order got st=%0d ld=%0d if=%0d want 2 6 13", t_st, t_ld, t_if);
        end
        total++;
        if (ld_v !== 32'h000000EF || if_v !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL prio_data got ld=%h if=%h want ef deadbeef", ld_v, if_v);
        end
        total++;
        if (mem[1024] !== 8'h5A) begin
            bad++;
            $display("FAIL prio_store got=%h want=5a", mem[1024]);
        end
    endtask

    task automatic test_rollback();
        logic saw_if;
        saw_if = 1'b0;
        if_addr = 32'h1000; if_req = 1'b1;
        tick();
        saw_if |= if_done;
        st_addr = 32'h500; st_size = ST_SB; st_data = 32'h000000A5; st_req = 1'b1;
        tick();
        saw_if |= if_done;
        total++;
        if (mem_a !== 32'h1001) begin
            bad++;
            $display("FAIL rb_byte1 got a=%h want=1001", mem_a);
        end
        rollback = 1'b1;
        tick();
        saw_if |= if_done;
        rollback = 1'b0; if_req = 1'b0;
        total++;
        if (mem_a !== 32'h1001 || mem_wr !== 1'b0) begin
            bad++;
            $display("FAIL rb_abort got a=%h wr=%b want a=1001 wr=0", mem_a, mem_wr);
        end
        tick();
        saw_if |= if_done;
        total++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h500 || mem_dout !== 8'hA5) begin
            bad++;
            $display("FAIL rb_st_grant got wr=%b a=%h d=%h want 1 500 a5", mem_wr, mem_a, mem_dout);
        end
        tick();
        saw_if |= if_done;
        total++;
        if (st_done !== 1'b1) begin
            bad++;
            $display("FAIL rb_st_done got=%b want=1", st_done);
        end
        st_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            saw_if |= if_done;
        end
        total++;
        if (saw_if !== 1'b0) begin
            bad++;
            $display("FAIL rb_no_if_done got=%b want=0", saw_if);
        end
    endtask

    task automatic test_rollback_idle();
        int n;
        ld_addr = 32'h200; ld_op = LD_LBU; ld_req = 1'b1; rollback = 1'b1;
        tick();
        rollback = 1'b0;
        total++;
        if (mem_a !== 32'h500) begin
            bad++;
            $display("FAIL rbi_blocked got a=%h want=500", mem_a);
        end
        n = 0;
        while (!ld_done && n < 20) begin
            tick();
            n++;
        end
        ld_req = 1'b0;
        total++;
        if (n != 3 || ld_data !== 32'h0000007F) begin
            bad++;
            $display("FAIL rbi_load got lat=%0d data=%h want 3 0000007f", n, ld_data);
        end
        tick();
    endtask

    task automatic test_rdy_stall();
        int base;
        base = wr_count;
        st_addr = 32'h300; st_size = ST_SW; st_data = 32'h11223344; st_req = 1'b1;
        tick();
        total++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h300 || mem_dout !== 8'h44) begin
            bad++;
            $display("FAIL rdy_b0 got wr=%b a=%h d=%h want 1 300 44", mem_wr, mem_a, mem_dout);
        end
        tick();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (mem_wr !== 1'b0 || mem_a !== 32'h301) begin
                bad++;
                $display("FAIL rdy_frozen%0d got wr=%b a=%h want 0 301", i, mem_wr, mem_a);
            end
        end
        rdy = 1'b1;
        tick();
        total++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h302 || mem_dout !== 8'h22) begin
            bad++;
            $display("FAIL rdy_b2 got wr=%b a=%h d=%h want 1 302 22", mem_wr, mem_a, mem_dout);
        end
        tick();
        tick();
        total++;
        if (st_done !== 1'b1 || mem_wr !== 1'b0) begin
            bad++;
            $display("FAIL rdy_done got done=%b wr=%b want 1 0", st_done, mem_wr);
        end
        st_req = 1'b0;
        tick();
        total++;
        if (wr_count - base != 4 || {mem[771], mem[770], mem[769], mem[768]} !== 32'h11223344) begin
            bad++;
            $display("FAIL rdy_mem got strobes=%0d word=%h want 4 11223344", wr_count - base,
                     {mem[771], mem[770], mem[769], mem[768]});
        end
    endtask

    task automatic test_io_stall();
        st_addr = 32'h30000; st_size = ST_SB; st_data = 32'h0000003C; st_req = 1'b1;
        io_buffer_full = 1'b1;
`ifdef MEM_IO_STALL_EN
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (mem_wr !== 1'b0) begin
                bad++;
                $display("FAIL io_stall%0d got wr=%b want 0", i, mem_wr);
            end
        end
        io_buffer_full = 1'b0;
`endif
        tick();
        total++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h30000 || mem_dout !== 8'h3C) begin
            bad++;
            $display("FAIL io_write got wr=%b a=%h d=%h want 1 30000 3c", mem_wr, mem_a, mem_dout);
        end
        io_buffer_full = 1'b0;
        tick();
        total++;
        if (st_done !== 1'b1 || mem[18'h30000] !== 8'h3C) begin
            bad++;
            $display("FAIL io_done got done=%b mem=%h want 1 3c", st_done, mem[18'h30000]);
        end
        st_req = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
        if_addr = '0; ld_addr = '0; st_addr = '0; st_data = '0; ld_op = LD_LB; st_size = ST_SB;
        test_reset();
        test_sw();
        test_load();
        test_priority();
        test_rollback();
        test_rollback_idle();
        test_rdy_stall();
        test_io_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
